// File: rtl/stab_mon_pkg.sv
// stab_mon_pkg: shared state encoding and sizing helper for the stability monitor
package stab_mon_pkg;

   typedef enum logic [1:0] {DISARMED, SETTLING, STABLE} stab_state_e;

   // Hold counter must be able to hold the value MIN_STABLE-1 (and stays >= 1 bit)
   function automatic int hold_cnt_width(input int min_stable);
      return (min_stable < 1) ? 1 : $clog2(min_stable + 1);
   endfunction

endpackage

// File: rtl/stab_mon_chan.sv
// stab_mon_chan: one monitored channel; optional violation counter under STAB_MON_VIOL_CNT_EN
module stab_mon_chan
   import stab_mon_pkg::*;
#(
   parameter int W = 8,
   parameter int MIN_STABLE = 4
`ifdef STAB_MON_VIOL_CNT_EN
   , parameter int CNT_W = 8
`endif
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] sig,
   input  logic         clr_sticky,
   output logic         viol,
   output logic         viol_sticky,
   output logic         stable
`ifdef STAB_MON_VIOL_CNT_EN
   , output logic [CNT_W-1:0] viol_cnt
`endif
);

   localparam int HW = hold_cnt_width(MIN_STABLE);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_STABLE - 1);

   stab_state_e state_q, state_d;
   logic [W-1:0] prev_q, prev_d;
   logic [HW-1:0] cnt_q, cnt_d;
   logic viol_d;
   logic chg;

   assign chg = (sig != prev_q);

   // Next-state: arm captures a reference, early changes are violations, changes after STABLE are legal
   always_comb begin
      state_d = state_q;
      prev_d = prev_q;
      cnt_d = cnt_q;
      viol_d = 1'b0;
      if (!en) begin
         state_d = DISARMED;
         cnt_d = '0;
      end else begin
         case (state_q)
            DISARMED: begin
               prev_d = sig;
               cnt_d = '0;
               state_d = SETTLING;
            end
            SETTLING: begin
               if (chg) begin
                  viol_d = 1'b1;
                  prev_d = sig;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  state_d = (cnt_q == HOLD_LAST) ? STABLE : SETTLING;
               end
            end
            STABLE: begin
               if (chg) begin
                  prev_d = sig;
                  cnt_d = '0;
                  state_d = SETTLING;
               end
            end
            default: state_d = DISARMED;
         endcase
      end
   end

   // State, reference value, hold count and registered violation flags; a new violation beats clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= DISARMED;
         prev_q <= '0;
         cnt_q <= '0;
         viol <= 1'b0;
         viol_sticky <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q <= prev_d;
         cnt_q <= cnt_d;
         viol <= viol_d;
         viol_sticky <= viol_d | (viol_sticky & ~clr_sticky);
      end
   end

   assign stable = (state_q == STABLE);

`ifdef STAB_MON_VIOL_CNT_EN
   // Saturating violation counter; clear restarts from this edge's violation (if any)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         viol_cnt <= '0;
      else if (clr_sticky)
         viol_cnt <= CNT_W'(viol_d);
      else if (viol_d && viol_cnt != '1)
         viol_cnt <= viol_cnt + 1'b1;
   end
`endif

endmodule

// File: rtl/multi_chan_stability_monitor.sv
// multi_chan_stability_monitor: NCH-channel windowed stability checker; STAB_MON_VIOL_CNT_EN adds viol_cnt
module multi_chan_stability_monitor
   import stab_mon_pkg::*;
#(
   parameter int NCH = 4,
   parameter int W = 8,
   parameter int MIN_STABLE = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   en,
   input  logic [NCH*W-1:0] sig,
   input  logic             clr_sticky,
   output logic [NCH-1:0]   viol,
   output logic [NCH-1:0]   viol_sticky,
   output logic [NCH-1:0]   stable,
   output logic             any_viol
`ifdef STAB_MON_VIOL_CNT_EN
   , output logic [NCH*CNT_W-1:0] viol_cnt
`endif
);

   if (NCH < 1 || W < 1 || MIN_STABLE < 1 || CNT_W < 1) begin : g_bad_param
      $error("multi_chan_stability_monitor: all parameters must be >= 1");
   end

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      stab_mon_chan #(
         .W(W),
         .MIN_STABLE(MIN_STABLE)
`ifdef STAB_MON_VIOL_CNT_EN
         , .CNT_W(CNT_W)
`endif
      ) u_chan (
         .clk(clk),
         .rst(rst),
         .en(en[i]),
         .sig(sig[i*W +: W]),
         .clr_sticky(clr_sticky),
         .viol(viol[i]),
         .viol_sticky(viol_sticky[i]),
         .stable(stable[i])
`ifdef STAB_MON_VIOL_CNT_EN
         , .viol_cnt(viol_cnt[i*CNT_W +: CNT_W])
`endif
      );
   end

   assign any_viol = |viol_sticky;

endmodule

// File: tb/tb_multi_chan_stability_monitor.sv
// tb_multi_chan_stability_monitor: directed + random checks against an age-based reference model
module tb_multi_chan_stability_monitor;

   localparam int NCH = 4;
   localparam int W = 8;
   localparam int MS = 4;
   localparam int CNT_W = 2;
   localparam int CMAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [NCH-1:0] en = '0;
   logic [NCH*W-1:0] sig = '0;
   logic clr_sticky = 1'b0;
   logic [NCH-1:0] viol, viol_sticky, stable;
   logic any_viol;
`ifdef STAB_MON_VIOL_CNT_EN
   logic [NCH*CNT_W-1:0] viol_cnt;
   logic [NCH*CNT_W-1:0] e_cnt;
`endif

   int checks = 0;
   int failures = 0;

   bit m_armed[NCH];
   int m_age[NCH];
   logic [W-1:0] m_ref[NCH];
   int m_cnt[NCH];
   logic [NCH-1:0] e_viol, e_sticky, e_stable;

   always #5 clk = ~clk;

   multi_chan_stability_monitor #(.NCH(NCH), .W(W), .MIN_STABLE(MS), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .sig(sig),
      .clr_sticky(clr_sticky),
      .viol(viol),
      .viol_sticky(viol_sticky),
      .stable(stable),
      .any_viol(any_viol)
`ifdef STAB_MON_VIOL_CNT_EN
      , .viol_cnt(viol_cnt)
`endif
   );

   task automatic set_ch(input int i, input logic [W-1:0] v);
      sig[i*W +: W] = v;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_armed[i] = 0;
         m_age[i] = 0;
         m_ref[i] = '0;
         m_cnt[i] = 0;
      end
      e_viol = '0;
      e_sticky = '0;
      e_stable = '0;
   endtask

   // A channel's value has an "age" in enabled samples; a change younger than MS samples is a violation
   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < NCH; i++) begin
         logic [W-1:0] s;
         bit nv;
         s = sig[i*W +: W];
         nv = 0;
         if (!en[i]) m_armed[i] = 0;
         else if (!m_armed[i]) begin
            m_armed[i] = 1;
            m_ref[i] = s;
            m_age[i] = 0;
         end else if (s != m_ref[i]) begin
            nv = (m_age[i] < MS);
            m_ref[i] = s;
            m_age[i] = 0;
         end else m_age[i]++;
         e_viol[i] = nv;
         e_sticky[i] = nv | (e_sticky[i] & ~clr_sticky);
         e_stable[i] = m_armed[i] && (m_age[i] >= MS);
         m_cnt[i] = clr_sticky ? int'(nv) : ((m_cnt[i] + int'(nv) > CMAX) ? CMAX : m_cnt[i] + int'(nv));
`ifdef STAB_MON_VIOL_CNT_EN
         e_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
`endif
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({viol, viol_sticky, stable, any_viol} !== '0) begin
         failures++;
         $display("FAIL reset: got viol=%b sticky=%b stable=%b any=%b, want all 0", viol, viol_sticky, stable, any_viol);
      end
`ifdef STAB_MON_VIOL_CNT_EN
      checks++;
      if (viol_cnt !== '0) begin
         failures++;
         $display("FAIL reset_cnt: got %h want 0", viol_cnt);
      end
`endif
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_stable_hold();
      set_ch(0, 8'h5A);
      en[0] = 1'b1;
      tick();
      for (int k = 1; k <= 6; k++) begin
         tick();
         checks++;
         if ({viol, viol_sticky, stable, any_viol} !== {e_viol, e_sticky, e_stable, |e_sticky}) begin
            failures++;
            $display("FAIL stable_hold k=%0d: got viol=%b sticky=%b stable=%b any=%b want %b %b %b %b",
                     k, viol, viol_sticky, stable, any_viol, e_viol, e_sticky, e_stable, |e_sticky);
         end
         if (k == 4) begin
            checks++;
            if (stable[0] !== 1'b1) begin
               failures++;
               $display("FAIL stable_hold_rise: got stable[0]=%b want 1", stable[0]);
            end
         end
      end
   endtask

   task automatic test_violation();
      set_ch(1, 8'h10);
      en[1] = 1'b1;
      tick();
      tick();
      set_ch(1, 8'h11);
      tick();
      checks++;
      if ({viol[1], viol_sticky[1], stable[1], any_viol} !== 4'b1101) begin
         failures++;
         $display("FAIL violation: got viol=%b sticky=%b stable=%b any=%b want 1 1 0 1",
                  viol[1], viol_sticky[1], stable[1], any_viol);
      end
      tick();
      checks++;
      if ({viol, viol_sticky, stable, any_viol} !== {e_viol, e_sticky, e_stable, |e_sticky} || viol[1] !== 1'b0) begin
         failures++;
         $display("FAIL violation_pulse_end: got viol=%b sticky=%b stable=%b want %b %b %b",
                  viol, viol_sticky, stable, e_viol, e_sticky, e_stable);
      end
   endtask

   task automatic test_legal_change();
      set_ch(2, 8'h33);
      en[2] = 1'b1;
      repeat (5) tick();
      set_ch(2, 8'h44);
      tick();
      checks++;
      if (stable[2] !== 1'b0 || viol[2] !== 1'b0 || viol_sticky[2] !== 1'b0) begin
         failures++;
         $display("FAIL legal_change: got stable=%b viol=%b sticky=%b want 0 0 0", stable[2], viol[2], viol_sticky[2]);
      end
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if ({viol, viol_sticky, stable} !== {e_viol, e_sticky, e_stable}) begin
            failures++;
            $display("FAIL legal_resettle k=%0d: got viol=%b sticky=%b stable=%b want %b %b %b",
                     k, viol, viol_sticky, stable, e_viol, e_sticky, e_stable);
         end
      end
      checks++;
      if (stable[2] !== 1'b1) begin
         failures++;
         $display("FAIL legal_rerise: got stable[2]=%b want 1", stable[2]);
      end
   endtask

   task automatic test_clr_priority();
      set_ch(1, 8'h20);
      tick();
      set_ch(1, 8'h21);
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      checks++;
      if (viol_sticky[1] !== 1'b1 || viol[1] !== 1'b1 || viol_sticky !== e_sticky) begin
         failures++;
         $display("FAIL clr_vs_set: got viol=%b sticky=%b want viol[1]=1 sticky=%b", viol, viol_sticky, e_sticky);
      end
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      checks++;
      if (viol_sticky !== '0 || any_viol !== 1'b0) begin
         failures++;
         $display("FAIL clr_alone: got sticky=%b any=%b want 0 0", viol_sticky, any_viol);
      end
   endtask

   task automatic test_disarm();
      logic [W-1:0] v;
      v = 8'hC3;
      set_ch(3, v);
      en[3] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k == 5) en[3] = 1'b0;
         if (k == 8) en[3] = 1'b1;
         tick();
         checks++;
         if ({viol, viol_sticky, stable} !== {e_viol, e_sticky, e_stable}) begin
            failures++;
            $display("FAIL disarm k=%0d: got viol=%b sticky=%b stable=%b want %b %b %b",
                     k, viol, viol_sticky, stable, e_viol, e_sticky, e_stable);
         end
         if (k == 5 || k == 8) begin
            checks++;
            if (viol[3] !== 1'b0) begin
               failures++;
               $display("FAIL disarm_edge k=%0d: got viol[3]=%b want 0", k, viol[3]);
            end
         end
         v = ~v;
         set_ch(3, v);
      end
   endtask

`ifdef STAB_MON_VIOL_CNT_EN
   task automatic test_saturation();
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      for (int k = 0; k < 6; k++) begin
         set_ch(0, 8'h5A ^ W'(k + 1));
         tick();
         checks++;
         if (viol_cnt !== e_cnt) begin
            failures++;
            $display("FAIL cnt k=%0d: got %h want %h", k, viol_cnt, e_cnt);
         end
      end
      checks++;
      if (viol_cnt[CNT_W-1:0] !== CNT_W'(CMAX)) begin
         failures++;
         $display("FAIL cnt_sat: got %0d want %0d", viol_cnt[CNT_W-1:0], CMAX);
      end
   endtask
`endif

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < NCH; i++) begin
            if ($urandom_range(0, 19) == 0) en[i] = ~en[i];
            if ($urandom_range(0, 3) == 0) set_ch(i, W'($urandom_range(0, 3)));
         end
         clr_sticky = ($urandom_range(0, 15) == 0);
         tick();
         checks++;
         if ({viol, viol_sticky, stable, any_viol} !== {e_viol, e_sticky, e_stable, |e_sticky}) begin
            failures++;
            $display("FAIL random k=%0d: got viol=%b sticky=%b stable=%b any=%b want %b %b %b %b",
                     k, viol, viol_sticky, stable, any_viol, e_viol, e_sticky, e_stable, |e_sticky);
         end
`ifdef STAB_MON_VIOL_CNT_EN
         checks++;
         if (viol_cnt !== e_cnt) begin
            failures++;
            $display("FAIL random_cnt k=%0d: got %h want %h", k, viol_cnt, e_cnt);
         end
`endif
      end
      clr_sticky = 1'b0;
   endtask

   task automatic test_async_reset();
      en = '1;
      for (int i = 0; i < NCH; i++) set_ch(i, 8'h00);
      tick();
      set_ch(0, 8'h01);
      tick();
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({viol, viol_sticky, stable, any_viol} !== '0) begin
         failures++;
         $display("FAIL async_reset: got viol=%b sticky=%b stable=%b any=%b want all 0", viol, viol_sticky, stable, any_viol);
      end
`ifdef STAB_MON_VIOL_CNT_EN
      checks++;
      if (viol_cnt !== '0) begin
         failures++;
         $display("FAIL async_reset_cnt: got %h want 0", viol_cnt);
      end
`endif
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      tick();
      checks++;
      if ({viol, viol_sticky, stable} !== {e_viol, e_sticky, e_stable}) begin
         failures++;
         $display("FAIL post_reset_arm: got viol=%b sticky=%b stable=%b want %b %b %b",
                  viol, viol_sticky, stable, e_viol, e_sticky, e_stable);
      end
   endtask

   initial begin
      test_reset();
      test_stable_hold();
      test_violation();
      test_legal_change();
      test_clr_priority();
      test_disarm();
`ifdef STAB_MON_VIOL_CNT_EN
      test_saturation();
`endif
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multi_chan_stability_monitor.md
# multi_chan_stability_monitor

Synthesizable, parametrised stability checker that watches NCH independent W-bit channels and flags any channel whose value changes before it has been held for MIN_STABLE consecutive clock samples. It generalises the single-signal, every-cycle `$stable` check into a windowed, per-channel, armable RTL monitor. It sits beside datapath or control buses, is usable in silicon and in simulation, and reports per-channel violation pulses, sticky flags and stable status.

## Interface
- NCH, 4, number of monitored channels (≥1)
- W, 8, width of each channel in bits (≥1)
- MIN_STABLE, 4, consecutive equal samples required before a change is legal (≥1)
- CNT_W, 8, width of each per-channel violation counter (only used with the configuration macro)
- clk  input  1  sampling clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-low
- en  input  NCH  per-channel arm; channel i monitored while en[i]=1
- sig  input  NCH*W  monitored values; channel i = sig[i*W +: W]
- clr_sticky  input  1  synchronous clear of viol_sticky (and counters when compiled in)
- viol  output  NCH  one-cycle registered violation pulse per channel
- viol_sticky  output  NCH  latched violation flag per channel
- stable  output  NCH  channel i is in STABLE state
- any_viol  output  1  OR-reduction of viol_sticky

## Operation
- Per-channel state: DISARMED, SETTLING, STABLE; per-channel prev register (W bits) and hold counter cnt (clog2(MIN_STABLE+1) bits).
- chg = (sig_i != prev_i), evaluated at each rising edge.
- en_i=0: go/stay DISARMED, cnt=0, no viol; disarming mid-SETTLING is silent.
- DISARMED with en_i=1 (arm edge): prev_i<=sig_i, cnt=0, go SETTLING; no comparison on the arm edge.
- SETTLING, chg=0: cnt<=cnt+1; if cnt+1==MIN_STABLE go STABLE.
- SETTLING, chg=1: viol_i pulses, viol_sticky_i set, prev_i<=sig_i, cnt=0, stay SETTLING.
- STABLE, chg=0: hold, cnt frozen.
- STABLE, chg=1: legal change, no viol; prev_i<=sig_i, cnt=0, go SETTLING.
- prev_i updates on every enabled edge with chg=1; otherwise holds.
- clr_sticky and a new violation on the same edge: set wins (viol_sticky stays 1).
- Channels fully independent; no arbitration.

## Timing
- Reset (rst=0): all states DISARMED, prev=0, cnt=0; viol, viol_sticky, stable, any_viol = 0 (viol_cnt = 0).
- viol_i, stable_i, viol_sticky_i are registered: visible in the cycle after the sampling edge that caused them.
- viol_i high for exactly one cycle per violating edge; back-to-back violations give consecutive high cycles.
- any_viol is combinational from viol_sticky (same cycle).
- After arm at edge t with sig held constant, stable_i rises after edge t+MIN_STABLE.
- Reset asserted mid-operation clears everything immediately (async); first arm edge is the first rising edge with rst=1 and en_i=1.

## Configuration
- Macro STAB_MON_VIOL_CNT_EN.
- Defined: adds output viol_cnt (NCH*CNT_W, channel i = viol_cnt[i*CNT_W +: CNT_W]); increments on each viol_i pulse, saturates at 2^CNT_W-1, cleared by clr_sticky (clear and increment on same edge: result 1) and by reset.
- Undefined: no counters, no viol_cnt port; all other behaviour identical.

## Structure
- Package stab_mon_pkg: typedef enum stab_state_e {DISARMED, SETTLING, STABLE}; function for counter width from MIN_STABLE.
- Sub-module stab_mon_chan (one channel: state, prev, cnt, viol, sticky, optional counter), instantiated NCH times in a generate loop; top does port slicing and any_viol.

## Test plan
- Reset then arm ch0 with sig=0x5A held 6 cycles -> stable[0]=1 after 4th edge following arm; viol=0 throughout.
- Arm ch1 at 0x10, change to 0x11 on 2nd edge after arm -> viol[1] one-cycle pulse, viol_sticky[1]=1, any_viol=1, stable[1] stays 0.
- Ch2 STABLE at 0x33, change to 0x44 -> no viol, stable[2] drops next cycle, re-rises 4 edges later if held.
- Pulse clr_sticky on same edge as new ch1 violation -> viol_sticky[1] remains 1; next clr_sticky alone -> 0, any_viol=0.
- Ch3 toggling every cycle with en[3] dropped mid-burst -> viol pulses stop on the first edge with en[3]=0, state DISARMED, no stale violation on re-arm.
- With STAB_MON_VIOL_CNT_EN, CNT_W=2: 5 violations on ch0 -> viol_cnt[0] saturates at 3; assert rst mid-count -> all outputs 0 asynchronously.
